ttt_game_ctrl: RTL and testbench

TTT_GAME_CTRL -- requirements
Module: ttt_game_ctrl

---
 rtl/ttt_game_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_ttt_game_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game controller: tracks the mouse cursor, maps clicks to board cells,
// validates and places marks, and judges win/draw for a two-player 3x3 game.
module ttt_game_ctrl #(
   parameter int BOARD_X0 = 170,
   parameter int BOARD_Y0 = 90,
   parameter int CELL     = 100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m_done_tick,
   input  logic [8:0]  xm,
   input  logic [8:0]  ym,
   input  logic [2:0]  btnm,
   output logic [9:0]  px,
   output logic [9:0]  py,
   output logic [17:0] board,
   output logic        turn,
   output logic        game_over,
   output logic [1:0]  winner,
   output logic        move_ok,
   output logic        move_rej
);

   typedef enum logic [1:0] {PLAY, VALIDATE, JUDGE, OVER} state_t;

   localparam logic [10:0] X_B0 = 11'(BOARD_X0);
   localparam logic [10:0] X_B1 = 11'(BOARD_X0 + CELL);
   localparam logic [10:0] X_B2 = 11'(BOARD_X0 + 2 * CELL);
   localparam logic [10:0] X_B3 = 11'(BOARD_X0 + 3 * CELL);
   localparam logic [10:0] Y_B0 = 11'(BOARD_Y0);
   localparam logic [10:0] Y_B1 = 11'(BOARD_Y0 + CELL);
   localparam logic [10:0] Y_B2 = 11'(BOARD_Y0 + 2 * CELL);
   localparam logic [10:0] Y_B3 = 11'(BOARD_Y0 + 3 * CELL);

   state_t      r_state;
   state_t      w_state_next;
   logic [9:0]  r_px;
   logic [9:0]  r_py;
   logic [9:0]  w_px_next;
   logic [9:0]  w_py_next;
   logic        r_btn_prev;
   logic [17:0] r_board;
   logic [17:0] w_board_next;
   logic        r_turn;
   logic        w_turn_next;
   logic [1:0]  r_winner;
   logic [1:0]  w_winner_next;
   logic [3:0]  r_cell;
   logic [3:0]  w_cell_next;
   logic        r_move_ok;
   logic        r_move_rej;
   logic        w_ok_next;
   logic        w_rej_next;

   logic signed [10:0] w_x_sum;
   logic signed [10:0] w_y_sum;
   logic [10:0] w_px_ext;
   logic [10:0] w_py_ext;
   logic        w_click;
   logic        w_in_board;
   logic [1:0]  w_col;
   logic [1:0]  w_row;
   logic [3:0]  w_cell;
   logic [1:0]  w_mark;
   logic [8:0]  w_mine;
   logic [8:0]  w_filled;
   logic        w_win;
   logic        w_unused_btn;

   assign w_unused_btn = ^btnm[2:1];

   // Motion math at 11-bit signed so the clamp sees true under/overflow.
   assign w_x_sum = $signed({1'b0, r_px}) + $signed({{2{xm[8]}}, xm});
   assign w_y_sum = $signed({1'b0, r_py}) - $signed({{2{ym[8]}}, ym});

   always_comb begin
      w_px_next = r_px;
      w_py_next = r_py;
      if (m_done_tick) begin
         if (w_x_sum < 11'sd0)
            w_px_next = 10'd0;
         else if (w_x_sum > 11'sd639)
            w_px_next = 10'd639;
         else
            w_px_next = w_x_sum[9:0];
         if (w_y_sum < 11'sd0)
            w_py_next = 10'd0;
         else if (w_y_sum > 11'sd479)
            w_py_next = 10'd479;
         else
            w_py_next = w_y_sum[9:0];
      end
   end

   assign w_click = m_done_tick & btnm[0] & ~r_btn_prev;

   // Cell decode uses the pre-motion cursor of the clicking packet.
   assign w_px_ext   = {1'b0, r_px};
   assign w_py_ext   = {1'b0, r_py};
   assign w_in_board = (w_px_ext >= X_B0) && (w_px_ext < X_B3) &&
                       (w_py_ext >= Y_B0) && (w_py_ext < Y_B3);
   assign w_col = (w_px_ext < X_B1) ? 2'd0 : (w_px_ext < X_B2) ? 2'd1 : 2'd2;
   assign w_row = (w_py_ext < Y_B1) ? 2'd0 : (w_py_ext < Y_B2) ? 2'd1 : 2'd2;
   assign w_cell = {1'b0, w_row, 1'b0} + {2'b00, w_row} + {2'b00, w_col};

   assign w_mark = r_turn ? 2'b10 : 2'b01;

   genvar gi;
   generate
      for (gi = 0; gi < 9; gi++) begin : g_cell
         assign w_mine[gi]   = (r_board[2*gi +: 2] == w_mark);
         assign w_filled[gi] = |r_board[2*gi +: 2];
      end
   endgenerate

   assign w_win = (w_mine[0] & w_mine[1] & w_mine[2]) |
                  (w_mine[3] & w_mine[4] & w_mine[5]) |
                  (w_mine[6] & w_mine[7] & w_mine[8]) |
                  (w_mine[0] & w_mine[3] & w_mine[6]) |
                  (w_mine[1] & w_mine[4] & w_mine[7]) |
                  (w_mine[2] & w_mine[5] & w_mine[8]) |
                  (w_mine[0] & w_mine[4] & w_mine[8]) |
                  (w_mine[2] & w_mine[4] & w_mine[6]);

   always_comb begin
      w_state_next  = r_state;
      w_board_next  = r_board;
      w_turn_next   = r_turn;
      w_winner_next = r_winner;
      w_cell_next   = r_cell;
      w_ok_next     = 1'b0;
      w_rej_next    = 1'b0;
      case (r_state)
         PLAY: begin
            if (w_click && w_in_board) begin
               w_cell_next  = w_cell;
               w_state_next = VALIDATE;
            end
         end
         VALIDATE: begin
            if (w_filled[r_cell]) begin
               w_rej_next   = 1'b1;
               w_state_next = PLAY;
            end else begin
               for (int i = 0; i < 9; i++) begin
                  if (r_cell == 4'(i))
                     w_board_next[2*i +: 2] = w_mark;
               end
               w_ok_next    = 1'b1;
               w_state_next = JUDGE;
            end
         end
         JUDGE: begin
            // A line on the final move beats the full-board draw.
            if (w_win) begin
               w_winner_next = w_mark;
               w_state_next  = OVER;
            end else if (&w_filled) begin
               w_winner_next = 2'b11;
               w_state_next  = OVER;
            end else begin
               w_turn_next  = ~r_turn;
               w_state_next = PLAY;
            end
         end
         OVER: begin
            if (w_click) begin
               w_board_next  = 18'd0;
               w_turn_next   = 1'b0;
               w_winner_next = 2'b00;
               w_state_next  = PLAY;
            end
         end
         default: w_state_next = PLAY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= PLAY;
         r_px       <= 10'd320;
         r_py       <= 10'd240;
         r_btn_prev <= 1'b0;
         r_board    <= 18'd0;
         r_turn     <= 1'b0;
         r_winner   <= 2'b00;
         r_cell     <= 4'd0;
         r_move_ok  <= 1'b0;
         r_move_rej <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_px       <= w_px_next;
         r_py       <= w_py_next;
         if (m_done_tick)
            r_btn_prev <= btnm[0];
         r_board    <= w_board_next;
         r_turn     <= w_turn_next;
         r_winner   <= w_winner_next;
         r_cell     <= w_cell_next;
         r_move_ok  <= w_ok_next;
         r_move_rej <= w_rej_next;
      end
   end

   assign px        = r_px;
   assign py        = r_py;
   assign board     = r_board;
   assign turn      = r_turn;
   assign winner    = r_winner;
   assign game_over = (r_state == OVER);
   assign move_ok   = r_move_ok;
   assign move_rej  = r_move_rej;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed bench for ttt_game_ctrl: cursor clamping, click timing, rejection,
// win/draw judging, restart from OVER and reset during JUDGE.
module tb_ttt_game_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        m_done_tick;
   logic [8:0]  xm;
   logic [8:0]  ym;
   logic [2:0]  btnm;
   logic [9:0]  px;
   logic [9:0]  py;
   logic [17:0] board;
   logic        turn;
   logic        game_over;
   logic [1:0]  winner;
   logic        move_ok;
   logic        move_rej;

   int errors = 0;
   int checks = 0;
   int cur_x  = 320;
   int cur_y  = 240;

   always #5 clk = ~clk;

   ttt_game_ctrl #(.BOARD_X0(170), .BOARD_Y0(90), .CELL(100)) dut (
      .clk(clk), .reset(reset), .m_done_tick(m_done_tick), .xm(xm), .ym(ym),
      .btnm(btnm), .px(px), .py(py), .board(board), .turn(turn),
      .game_over(game_over), .winner(winner), .move_ok(move_ok), .move_rej(move_rej)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One mouse packet; returns at the falling edge after it was sampled.
   task automatic send(input int dx, input int dy_up, input logic b);
      @(negedge clk);
      m_done_tick = 1'b1;
      xm   = 9'(dx);
      ym   = 9'(dy_up);
      btnm = {2'b00, b};
      @(negedge clk);
      m_done_tick = 1'b0;
      xm = 9'd0;
      ym = 9'd0;
   endtask

   task automatic go_to(input int x, input int y);
      int dx, dy;
      while (cur_x != x || cur_y != y) begin
         dx = x - cur_x;
         dy = y - cur_y;
         if (dx > 200) dx = 200;
         if (dx < -200) dx = -200;
         if (dy > 200) dy = 200;
         if (dy < -200) dy = -200;
         send(dx, -dy, 1'b0);
         cur_x += dx;
         cur_y += dy;
      end
      chk("goto_px", 32'(px), 32'(x));
      chk("goto_py", 32'(py), 32'(y));
   endtask

   // Full accepted move on a cell centre; checks the pulse and the T+3 game_over.
   task automatic move(input int c, input logic exp_over);
      go_to(220 + (c % 3) * 100, 140 + (c / 3) * 100);
      send(0, 0, 1'b1);
      @(negedge clk);
      chk("move_ok_T2", 32'(move_ok), 32'd1);
      chk("move_rej_T2", 32'(move_rej), 32'd0);
      @(negedge clk);
      chk("game_over_T3", 32'(game_over), 32'(exp_over));
      send(0, 0, 1'b0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      cur_x = 320;
      cur_y = 240;
   endtask

   initial begin
      reset = 1'b1;
      m_done_tick = 1'b0;
      xm = 9'd0;
      ym = 9'd0;
      btnm = 3'd0;
      repeat (3) @(negedge clk);
      chk("rst_px", 32'(px), 32'd320);
      chk("rst_py", 32'(py), 32'd240);
      chk("rst_board", 32'(board), 32'd0);
      chk("rst_turn", 32'(turn), 32'd0);
      chk("rst_winner", 32'(winner), 32'd0);
      chk("rst_over", 32'(game_over), 32'd0);
      chk("rst_ok", 32'(move_ok), 32'd0);
      chk("rst_rej", 32'(move_rej), 32'd0);
      reset = 1'b0;

      // Cursor motion and clamping
      send(10, 5, 1'b0);
      chk("mv_px", 32'(px), 32'd330);
      chk("mv_py", 32'(py), 32'd235);
      send(-144, 0, 1'b0);
      chk("mv_neg_px", 32'(px), 32'd186);
      send(-144, 0, 1'b0);
      send(-144, 0, 1'b0);
      chk("clamp_px_lo", 32'(px), 32'd0);
      repeat (3) send(255, 0, 1'b0);
      chk("clamp_px_hi", 32'(px), 32'd639);
      send(0, 255, 1'b0);
      chk("clamp_py_lo", 32'(py), 32'd0);
      send(0, -256, 1'b0);
      send(0, -256, 1'b0);
      chk("clamp_py_hi", 32'(py), 32'd479);
      cur_x = 639;
      cur_y = 479;

      // First move at (175,95) and its latency
      go_to(175, 95);
      send(0, 0, 1'b1);
      chk("T1_board", 32'(board), 32'd0);
      chk("T1_ok", 32'(move_ok), 32'd0);
      @(negedge clk);
      chk("T2_board", 32'(board), 32'h1);
      chk("T2_ok", 32'(move_ok), 32'd1);
      chk("T2_rej", 32'(move_rej), 32'd0);
      @(negedge clk);
      chk("T3_turn", 32'(turn), 32'd1);
      chk("T3_ok", 32'(move_ok), 32'd0);
      send(0, 0, 1'b0);

      // Same cell again is rejected
      send(0, 0, 1'b1);
      @(negedge clk);
      chk("rej_T2", 32'(move_rej), 32'd1);
      chk("rej_ok_T2", 32'(move_ok), 32'd0);
      chk("rej_board", 32'(board), 32'h1);
      @(negedge clk);
      chk("rej_T3", 32'(move_rej), 32'd0);
      chk("rej_turn", 32'(turn), 32'd1);
      send(0, 0, 1'b0);

      // Held button across two packets gives one move
      go_to(320, 240);
      send(0, 0, 1'b1);
      @(negedge clk);
      chk("held_ok", 32'(move_ok), 32'd1);
      @(negedge clk);
      send(0, 0, 1'b1);
      repeat (3) @(negedge clk);
      chk("held_board", 32'(board), 32'h201);
      chk("held_turn", 32'(turn), 32'd0);
      send(0, 0, 1'b0);

      // Off-board click
      go_to(100, 100);
      send(0, 0, 1'b1);
      repeat (3) @(negedge clk);
      chk("off_board", 32'(board), 32'h201);
      chk("off_turn", 32'(turn), 32'd0);
      chk("off_ok", 32'(move_ok), 32'd0);
      send(0, 0, 1'b0);

      // X wins the top row
      do_reset();
      move(0, 1'b0);
      move(3, 1'b0);
      move(1, 1'b0);
      move(4, 1'b0);
      move(2, 1'b1);
      chk("win_winner", 32'(winner), 32'd1);
      chk("win_board", 32'(board), 32'h295);
      chk("win_turn", 32'(turn), 32'd0);
      send(0, 0, 1'b1);
      chk("clr_board", 32'(board), 32'd0);
      chk("clr_turn", 32'(turn), 32'd0);
      chk("clr_winner", 32'(winner), 32'd0);
      chk("clr_over", 32'(game_over), 32'd0);
      send(0, 0, 1'b0);

      // Draw
      move(0, 1'b0);
      move(1, 1'b0);
      move(2, 1'b0);
      move(4, 1'b0);
      move(3, 1'b0);
      move(5, 1'b0);
      move(7, 1'b0);
      move(6, 1'b0);
      move(8, 1'b1);
      chk("draw_winner", 32'(winner), 32'd3);
      chk("draw_board", 32'(board), 32'h16A59);
      send(0, 0, 1'b1);
      send(0, 0, 1'b0);

      // Ninth move completes a diagonal: win beats draw
      move(0, 1'b0);
      move(1, 1'b0);
      move(2, 1'b0);
      move(5, 1'b0);
      move(3, 1'b0);
      move(6, 1'b0);
      move(8, 1'b0);
      move(7, 1'b0);
      move(4, 1'b1);
      chk("ninth_winner", 32'(winner), 32'd1);
      send(0, 0, 1'b1);
      send(0, 0, 1'b0);

      // Reset while in JUDGE
      go_to(220, 140);
      send(0, 0, 1'b1);
      @(negedge clk);
      chk("judge_ok", 32'(move_ok), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("jr_ok", 32'(move_ok), 32'd0);
      chk("jr_board", 32'(board), 32'd0);
      chk("jr_turn", 32'(turn), 32'd0);
      chk("jr_winner", 32'(winner), 32'd0);
      chk("jr_over", 32'(game_over), 32'd0);
      chk("jr_px", 32'(px), 32'd320);
      chk("jr_py", 32'(py), 32'd240);
      reset = 1'b0;
      cur_x = 320;
      cur_y = 240;
      send(0, 0, 1'b0);
      move(4, 1'b0);
      chk("post_rst_board", 32'(board), 32'h100);
      chk("post_rst_turn", 32'(turn), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
